// File: rtl/enc_step_tracker_pkg.sv
// Shared types and helpers for the multi-channel encoder step tracker.
package enc_pkg;

    // Per-channel tracking state: INIT waits for a first sample to load prev.
    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } enc_state_t;

    // Signed change between two W-bit counts. With wrap enabled the raw
    // difference is folded into the W-bit two's complement range so a
    // counter rolling over 2^W-1 -> 0 reads as a small step.
    function automatic int enc_delta(input int enc, input int prev,
                                     input int w, input int wrap);
        int d;
        int span;
        span = 32'sd1 << w;
        d    = enc - prev;
        if (wrap != 32'sd0) begin
            d = d & (span - 32'sd1);
            if (d >= (span >>> 1)) begin
                d = d - span;
            end else begin
                d = d;
            end
        end else begin
            d = d;
        end
        return d;
    endfunction

    // Signed width that holds acc + any accepted delta without overflow.
    function automatic int acc_width(input int step_div, input int max_jump);
        return $clog2(step_div + max_jump) + 32'sd1;
    endfunction

endpackage

// File: rtl/enc_step_chan.sv
// One encoder channel: delta, jump check, sub-step accumulation, step
// pulses and saturating position.
module enc_step_chan
    import enc_pkg::*;
#(
    parameter int W        = 5,
    parameter int WRAP     = 1,
    parameter int STEP_DIV = 1,
    parameter int MAX_JUMP = 4,
    parameter int POS_W    = 10
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [W-1:0]            enc,
    input  logic                    sample_en,
    input  logic                    clear,
    output logic                    increase,
    output logic                    decrease,
    output logic signed [POS_W-1:0] pos,
    output logic                    jump_err
);

    localparam int AW = acc_width(STEP_DIV, MAX_JUMP);

    localparam logic signed [W:0]       MJ_POS   = (W+1)'(MAX_JUMP);
    localparam logic signed [W:0]       MJ_NEG   = -MJ_POS;
    localparam logic signed [AW-1:0]    STEP_P   = AW'(STEP_DIV);
    localparam logic signed [AW-1:0]    STEP_N   = -STEP_P;
    localparam logic signed [AW-1:0]    ACC_MAX  = AW'(STEP_DIV - 1);
    localparam logic signed [AW-1:0]    ACC_MIN  = -ACC_MAX;
    localparam logic signed [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic signed [POS_W-1:0] POS_MAX  = POS_W'((32'sd1 << (POS_W - 1)) - 32'sd1);
    localparam logic signed [POS_W-1:0] POS_MIN  = -POS_MAX - POS_ONE;

    enc_state_t               state_r;
    logic [W-1:0]             prev_r;
    logic signed [AW-1:0]     acc_r;
    logic signed [POS_W-1:0]  pos_r;
    logic                     inc_r;
    logic                     dec_r;
    logic                     err_r;

    logic signed [W:0]        delta_s;
    logic                     jump_s;
    logic signed [AW-1:0]     sum_s;
    logic signed [AW-1:0]     adj_s;
    logic signed [AW-1:0]     acc_next_s;
    logic                     up_s;
    logic                     dn_s;
    logic signed [POS_W-1:0]  pos_up_s;
    logic signed [POS_W-1:0]  pos_dn_s;

    // Delta, plausibility check, step decision and next accumulator/position.
    always_comb begin
        delta_s    = (W+1)'(enc_delta(int'(enc), int'(prev_r), W, WRAP));
        jump_s     = (delta_s > MJ_POS) || (delta_s < MJ_NEG);
        sum_s      = acc_r + AW'(delta_s);
        up_s       = 1'b0;
        dn_s       = 1'b0;
        adj_s      = sum_s;
        if (sum_s >= STEP_P) begin
            up_s  = 1'b1;
            adj_s = sum_s - STEP_P;
        end else if (sum_s <= STEP_N) begin
            dn_s  = 1'b1;
            adj_s = sum_s + STEP_P;
        end else begin
            adj_s = sum_s;
        end
        // Motion beyond one step per sample is dropped, not carried.
        if (adj_s > ACC_MAX) begin
            acc_next_s = ACC_MAX;
        end else if (adj_s < ACC_MIN) begin
            acc_next_s = ACC_MIN;
        end else begin
            acc_next_s = adj_s;
        end
        pos_up_s = (pos_r == POS_MAX) ? pos_r : (pos_r + POS_ONE);
        pos_dn_s = (pos_r == POS_MIN) ? pos_r : (pos_r - POS_ONE);
    end

    // Channel FSM with registered pulses, position and sticky error.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_INIT;
            prev_r  <= {W{1'b0}};
            acc_r   <= {AW{1'b0}};
            pos_r   <= {POS_W{1'b0}};
            inc_r   <= 1'b0;
            dec_r   <= 1'b0;
            err_r   <= 1'b0;
        end else if (clear) begin
            state_r <= ST_INIT;
            prev_r  <= {W{1'b0}};
            acc_r   <= {AW{1'b0}};
            pos_r   <= {POS_W{1'b0}};
            inc_r   <= 1'b0;
            dec_r   <= 1'b0;
            err_r   <= 1'b0;
        end else if (sample_en) begin
            case (state_r)
                ST_INIT: begin
                    prev_r  <= enc;
                    state_r <= ST_TRACK;
                    inc_r   <= 1'b0;
                    dec_r   <= 1'b0;
                end
                ST_TRACK: begin
                    prev_r <= enc;
                    if (jump_s) begin
                        err_r <= 1'b1;
                        inc_r <= 1'b0;
                        dec_r <= 1'b0;
                    end else begin
                        acc_r <= acc_next_s;
                        inc_r <= up_s;
                        dec_r <= dn_s;
                        if (up_s) begin
                            pos_r <= pos_up_s;
                        end else if (dn_s) begin
                            pos_r <= pos_dn_s;
                        end else begin
                            pos_r <= pos_r;
                        end
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                    inc_r   <= 1'b0;
                    dec_r   <= 1'b0;
                end
            endcase
        end else begin
            inc_r <= 1'b0;
            dec_r <= 1'b0;
        end
    end

    assign increase = inc_r;
    assign decrease = dec_r;
    assign pos      = pos_r;
    assign jump_err = err_r;

endmodule

// File: rtl/enc_step_tracker.sv
// Multi-channel encoder step tracker: one enc_step_chan per channel with
// the flat buses sliced per channel.
module enc_step_tracker
    import enc_pkg::*;
#(
    parameter int N_CH     = 2,
    parameter int W        = 5,
    parameter int WRAP     = 1,
    parameter int STEP_DIV = 1,
    parameter int MAX_JUMP = 4,
    parameter int POS_W    = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_CH*W-1:0]     enc_in,
    input  logic                  sample_en,
    input  logic [N_CH-1:0]       clear,
    output logic [N_CH-1:0]       increase,
    output logic [N_CH-1:0]       decrease,
    output logic [N_CH*POS_W-1:0] pos_out,
    output logic [N_CH-1:0]       jump_err
);

    for (genvar i = 0; i < N_CH; i++) begin : g_chan
        enc_step_chan #(
            .W        (W),
            .WRAP     (WRAP),
            .STEP_DIV (STEP_DIV),
            .MAX_JUMP (MAX_JUMP),
            .POS_W    (POS_W)
        ) u_chan (
            .clk       (clk),
            .reset     (reset),
            .enc       (enc_in[i*W +: W]),
            .sample_en (sample_en),
            .clear     (clear[i]),
            .increase  (increase[i]),
            .decrease  (decrease[i]),
            .pos       (pos_out[i*POS_W +: POS_W]),
            .jump_err  (jump_err[i])
        );
    end

endmodule

// File: tb/tb_enc_step_tracker.sv
// Scoreboard bench for enc_step_tracker: instance A (wrap, STEP_DIV=1,
// POS_W=4) and instance B (no wrap, STEP_DIV=4, POS_W=10).
module tb_enc_step_tracker;

    typedef struct {
        logic [1:0] inc;
        logic [1:0] dec;
        logic [1:0] err;
        int         pos0;
        int         pos1;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic [9:0] enc_a = 10'd0;
    logic       se_a  = 1'b0;
    logic [1:0] clr_a = 2'd0;
    logic [1:0] inc_a, dec_a, err_a;
    logic [7:0] pos_a;

    logic [9:0] enc_b = 10'd0;
    logic       se_b  = 1'b0;
    logic [1:0] clr_b = 2'd0;
    logic [1:0] inc_b, dec_b, err_b;
    logic [19:0] pos_b;

    logic chk_a = 1'b0, chk_b = 1'b0;
    logic chk_a_d = 1'b0, chk_b_d = 1'b0;
    logic started = 1'b0;

    exp_t qa[$];
    exp_t qb[$];

    int checks = 0;
    int errors = 0;

    enc_step_tracker #(.N_CH(2), .W(5), .WRAP(1), .STEP_DIV(1), .MAX_JUMP(4), .POS_W(4)) u_dut_a (
        .clk(clk), .reset(reset), .enc_in(enc_a), .sample_en(se_a), .clear(clr_a),
        .increase(inc_a), .decrease(dec_a), .pos_out(pos_a), .jump_err(err_a)
    );

    enc_step_tracker #(.N_CH(2), .W(5), .WRAP(0), .STEP_DIV(4), .MAX_JUMP(4), .POS_W(10)) u_dut_b (
        .clk(clk), .reset(reset), .enc_in(enc_b), .sample_en(se_b), .clear(clr_b),
        .increase(inc_b), .decrease(dec_b), .pos_out(pos_b), .jump_err(err_b)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    // Remember which instances were stimulated on this edge.
    always @(posedge clk) begin
        chk_a_d <= chk_a;
        chk_b_d <= chk_b;
    end

    // Monitor: pop and compare after a stimulated edge, else require no pulses.
    always @(negedge clk) begin
        exp_t e;
        if (started) begin
            if (chk_a_d) begin
                if (qa.size() == 0) begin
                    cmp("a_queue_underflow", 1, 0);
                end else begin
                    e = qa.pop_front();
                    cmp("a_inc", int'(inc_a), int'(e.inc));
                    cmp("a_dec", int'(dec_a), int'(e.dec));
                    cmp("a_err", int'(err_a), int'(e.err));
                    cmp("a_pos0", int'($signed(pos_a[3:0])), e.pos0);
                    cmp("a_pos1", int'($signed(pos_a[7:4])), e.pos1);
                end
            end else begin
                cmp("a_idle_inc", int'(inc_a), 0);
                cmp("a_idle_dec", int'(dec_a), 0);
            end
            if (chk_b_d) begin
                if (qb.size() == 0) begin
                    cmp("b_queue_underflow", 1, 0);
                end else begin
                    e = qb.pop_front();
                    cmp("b_inc", int'(inc_b), int'(e.inc));
                    cmp("b_dec", int'(dec_b), int'(e.dec));
                    cmp("b_err", int'(err_b), int'(e.err));
                    cmp("b_pos0", int'($signed(pos_b[9:0])), e.pos0);
                    cmp("b_pos1", int'($signed(pos_b[19:10])), e.pos1);
                end
            end else begin
                cmp("b_idle_inc", int'(inc_b), 0);
                cmp("b_idle_dec", int'(dec_b), 0);
            end
        end
    end

    task automatic step_a(input logic [4:0] e0, input logic [4:0] e1, input logic [1:0] clr,
                          input logic se, input logic [1:0] xi, input logic [1:0] xd,
                          input int p0, input int p1, input logic [1:0] xe);
        exp_t e;
        e.inc = xi; e.dec = xd; e.err = xe; e.pos0 = p0; e.pos1 = p1;
        qa.push_back(e);
        enc_a = {e1, e0}; clr_a = clr; se_a = se; chk_a = 1'b1;
        @(posedge clk); #1;
        se_a = 1'b0; clr_a = 2'd0; chk_a = 1'b0;
    endtask

    task automatic step_b(input logic [4:0] e0, input logic [4:0] e1, input logic [1:0] clr,
                          input logic se, input logic [1:0] xi, input logic [1:0] xd,
                          input int p0, input int p1, input logic [1:0] xe);
        exp_t e;
        e.inc = xi; e.dec = xd; e.err = xe; e.pos0 = p0; e.pos1 = p1;
        qb.push_back(e);
        enc_b = {e1, e0}; clr_b = clr; se_b = se; chk_b = 1'b1;
        @(posedge clk); #1;
        se_b = 1'b0; clr_b = 2'd0; chk_b = 1'b0;
    endtask

    task automatic do_reset();
        exp_t z;
        z.inc = 2'd0; z.dec = 2'd0; z.err = 2'd0; z.pos0 = 0; z.pos1 = 0;
        qa.push_back(z);
        qb.push_back(z);
        reset = 1'b1; chk_a = 1'b1; chk_b = 1'b1;
        @(posedge clk); #1;
        chk_a = 1'b0; chk_b = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    initial begin
        @(posedge clk); #1;
        started = 1'b1;
        do_reset();

        // A: first sample is an INIT load, second gives a step up.
        step_a(5'd7,  5'd0,  2'b00, 1'b1, 2'b00, 2'b00, 0, 0, 2'b00);
        step_a(5'd8,  5'd0,  2'b00, 1'b1, 2'b01, 2'b00, 1, 0, 2'b00);
        idle();
        // A: wrap-around on ch1, 0 -> 31 -> 0 -> 31.
        step_a(5'd8,  5'd31, 2'b00, 1'b1, 2'b00, 2'b10, 1, -1, 2'b00);
        step_a(5'd8,  5'd0,  2'b00, 1'b1, 2'b10, 2'b00, 1, 0, 2'b00);
        step_a(5'd8,  5'd31, 2'b00, 1'b1, 2'b00, 2'b10, 1, -1, 2'b00);
        idle();
        // A: ch0 +1 and ch1 -2 on the same sample.
        step_a(5'd9,  5'd29, 2'b00, 1'b1, 2'b01, 2'b10, 2, -2, 2'b00);
        // A: clear ch1 alongside a sample; ch0 still steps.
        step_a(5'd10, 5'd5,  2'b10, 1'b1, 2'b01, 2'b00, 3, 0, 2'b00);
        step_a(5'd10, 5'd7,  2'b00, 1'b1, 2'b00, 2'b00, 3, 0, 2'b00);
        // A: delta of exactly MAX_JUMP accepted, then +5 rejected.
        step_a(5'd14, 5'd8,  2'b00, 1'b1, 2'b11, 2'b00, 4, 1, 2'b00);
        step_a(5'd19, 5'd8,  2'b00, 1'b1, 2'b00, 2'b00, 4, 1, 2'b01);
        step_a(5'd20, 5'd8,  2'b00, 1'b1, 2'b01, 2'b00, 5, 1, 2'b01);
        idle();
        // A: clear without sample drops error and position.
        step_a(5'd20, 5'd8,  2'b01, 1'b0, 2'b00, 2'b00, 0, 1, 2'b00);
        step_a(5'd0,  5'd8,  2'b00, 1'b1, 2'b00, 2'b00, 0, 1, 2'b00);
        // A: nine +1 samples, position saturates at 7 while pulses continue.
        for (int k = 1; k <= 9; k++) begin
            step_a(5'(k), 5'd8, 2'b00, 1'b1, 2'b01, 2'b00, (k > 7) ? 7 : k, 1, 2'b00);
        end

        // B: WRAP=0 jump, clear, then sub-step accumulation.
        step_b(5'd31, 5'd0, 2'b00, 1'b1, 2'b00, 2'b00, 0, 0, 2'b00);
        step_b(5'd0,  5'd0, 2'b00, 1'b1, 2'b00, 2'b00, 0, 0, 2'b01);
        step_b(5'd0,  5'd0, 2'b01, 1'b0, 2'b00, 2'b00, 0, 0, 2'b00);
        step_b(5'd10, 5'd0, 2'b00, 1'b1, 2'b00, 2'b00, 0, 0, 2'b00);
        step_b(5'd11, 5'd0, 2'b00, 1'b1, 2'b00, 2'b00, 0, 0, 2'b00);
        step_b(5'd12, 5'd0, 2'b00, 1'b1, 2'b00, 2'b00, 0, 0, 2'b00);
        step_b(5'd13, 5'd0, 2'b00, 1'b1, 2'b00, 2'b00, 0, 0, 2'b00);
        step_b(5'd14, 5'd0, 2'b00, 1'b1, 2'b01, 2'b00, 1, 0, 2'b00);
        step_b(5'd17, 5'd4, 2'b00, 1'b1, 2'b10, 2'b00, 1, 1, 2'b00);
        step_b(5'd14, 5'd0, 2'b00, 1'b1, 2'b00, 2'b10, 1, 0, 2'b00);
        step_b(5'd18, 5'd0, 2'b00, 1'b1, 2'b01, 2'b00, 2, 0, 2'b00);
        step_b(5'd21, 5'd0, 2'b00, 1'b1, 2'b00, 2'b00, 2, 0, 2'b00);
        step_b(5'd22, 5'd0, 2'b00, 1'b1, 2'b01, 2'b00, 3, 0, 2'b00);

        // Reset mid-operation: everything returns to zero and INIT.
        do_reset();
        step_a(5'd10, 5'd8, 2'b00, 1'b1, 2'b00, 2'b00, 0, 0, 2'b00);
        step_a(5'd11, 5'd8, 2'b00, 1'b1, 2'b01, 2'b00, 1, 0, 2'b00);
        step_b(5'd5,  5'd0, 2'b00, 1'b1, 2'b00, 2'b00, 0, 0, 2'b00);
        step_b(5'd9,  5'd0, 2'b00, 1'b1, 2'b01, 2'b00, 1, 0, 2'b00);

        idle();
        idle();
        cmp("a_queue_drained", qa.size(), 0);
        cmp("b_queue_drained", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enc_step_tracker.md
Name: enc_step_tracker

Overview:
- Multi-channel successor to the single-channel encoder comparator.
- Tracks N_CH debounced rotary-encoder count values, computes the signed change per sample, and handles counter wrap-around.
- Accumulates sub-step motion against a divider and emits one-cycle increase/decrease pulses per channel.
- Maintains a saturating signed position per channel and flags implausible jumps. Sits between the debouncers and the cursor/draw logic.

Parameters:
- N_CH, 2, number of encoder channels
- W, 5, width of each encoder count input
- WRAP, 1, 1 = delta taken modulo 2^W (counter wraps); 0 = plain signed difference
- STEP_DIV, 1, counts of accumulated motion per output step (>=1)
- MAX_JUMP, 4, largest |delta| accepted per sample (1..2^(W-1)-1)
- POS_W, 10, width of signed position output per channel

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enc_in  in  N_CH*W  channel i count at [i*W +: W]
- sample_en  in  1  sample strobe; all channels sampled together
- clear  in  N_CH  per-channel return to INIT state
- increase  out  N_CH  one-cycle step-up pulse per channel
- decrease  out  N_CH  one-cycle step-down pulse per channel
- pos_out  out  N_CH*POS_W  signed position, channel i at [i*POS_W +: POS_W]
- jump_err  out  N_CH  sticky per-channel implausible-jump flag

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high; it has priority over everything else.
- Reset values: increase=0, decrease=0, pos_out=0, jump_err=0; every channel in INIT with acc=0 and prev=0.
- Per-channel FSM:
  - ST_INIT: on sample_en, prev<=enc_in[i], go to ST_TRACK. No pulse and no error, so no spurious step on the first sample.
  - ST_TRACK: on sample_en, compute delta (below), then prev<=enc_in[i] unconditionally.
- Delta:
  - WRAP=1: delta = (enc - prev) mod 2^W, read as W-bit two's complement. Range -2^(W-1)..2^(W-1)-1.
  - WRAP=0: delta = enc - prev in W+1-bit signed.
- Jump check: if |delta| > MAX_JUMP, set jump_err[i], leave acc unchanged, emit no pulse.
- Accumulation, otherwise: s = acc + delta.
  - If s >= STEP_DIV: increase pulse, s -= STEP_DIV.
  - Else if s <= -STEP_DIV: decrease pulse, s += STEP_DIV.
  - acc <= s saturated to [-(STEP_DIV-1), STEP_DIV-1]; excess is discarded.
  - At most one pulse per channel per sample.
- Latency: pulses assert in the cycle after the sample_en cycle and last exactly one cycle. With no sample_en, pulses are 0. increase and decrease are never both 1 on one channel.
- Position: pos_out updates in the same cycle as the pulse (+1 on increase, -1 on decrease). It saturates at 2^(POS_W-1)-1 and -2^(POS_W-1); the pulse is still emitted at saturation.
- clear[i]: channel goes to ST_INIT, acc=0, jump_err=0, pos=0, no pulse next cycle.
  - Overrides a simultaneous sample_en for that channel only; other channels sample normally.
- Zero delta: no pulse, acc unchanged.
- STEP_DIV=1: acc is always 0, and any nonzero accepted delta gives exactly one pulse.
- Reset mid-operation: pending accumulation is discarded; the next sample after reset is an INIT load.

Decomposition:
- Shared package enc_pkg:
  - state typedef (ST_INIT, ST_TRACK)
  - wrap-aware delta function parameterised by W and WRAP
  - helper for accumulator width: clog2(STEP_DIV + MAX_JUMP) + 1 bits signed
- Sub-module enc_step_chan holds one channel (FSM, prev, acc, pos, err). The top instantiates N_CH copies in a generate loop and slices the buses.

Test Plan:
- Reset, then sample enc=7 on ch0 -> no pulse (INIT load); next sample enc=8 -> increase[0]=1 for one cycle the following cycle, pos_out ch0=1.
- W=5, WRAP=1: prev=31, sample 0 -> delta=+1, increase pulse. Prev=0, sample 31 -> decrease pulse, pos back to 0.
- WRAP=0, MAX_JUMP=4: prev=31, sample 0 -> delta=-31, jump_err[0]=1, no pulse, pos unchanged. clear[0] -> jump_err=0, INIT.
- STEP_DIV=4: deltas +1,+1,+1 -> no pulse; 4th +1 -> one increase, acc=0. Then +3 then -3 -> no pulses, acc=0.
- N_CH=2, same cycle: ch0 +1 and ch1 -2 with STEP_DIV=1 -> increase[0]=1 and decrease[1]=1 together; clear[1] with sample_en -> only ch0 updates.
- POS_W=4: 9 consecutive +1 samples -> pos saturates at 7, increase still pulses each sample. Assert reset mid-sequence -> all outputs 0 on the next cycle.
